multicycle_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 8-bit, 4-register microprocessor datapath.

---
 rtl/multicycle_sequencer_if.sv | 34 +++
 rtl/multicycle_sequencer.sv | 125 ++++++++++++
 tb/tb_multicycle_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: instruction handshake, data-memory ack and datapath control bundle
// master: the sequencer (drives instr_ready, controls, busy, retired_count, timeout_err)
// slave:  the instruction source / datapath (drives instr_valid, instr, mem_ack)
interface multicycle_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             instr_valid;
    logic [7:0]       instr;
    logic             instr_ready;
    logic             mem_ack;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src;
    logic             branch;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic [1:0]       alu_op;
    logic             busy;
    logic [CNT_W-1:0] retired_count;
    logic             timeout_err;

    modport master (
        input  instr_valid, instr, mem_ack,
        output instr_ready, reg_dst, reg_write, alu_src, branch, mem_read, mem_write,
               mem_to_reg, alu_op, busy, retired_count, timeout_err
    );

    modport slave (
        output instr_valid, instr, mem_ack,
        input  instr_ready, reg_dst, reg_write, alu_src, branch, mem_read, mem_write,
               mem_to_reg, alu_op, busy, retired_count, timeout_err
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: DECODE/EXEC/MEM/WB control FSM for the 8-bit, 4-register datapath
// Ports: clk (rising edge), rst_n (synchronous, active-low),
//        bus (multicycle_sequencer_if.master: instr handshake, mem_ack, datapath controls,
//        busy, retired_count, sticky timeout_err)
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    multicycle_sequencer_if.master bus
);
    localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_LW, OP_SW, OP_BEQ} op_t;

    state_t           state_q, state_d;
    logic [7:0]       ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             retire;
    op_t              op;

    assign op = op_t'(ir_q[7:6]);

    always_comb begin
        state_d = state_q;
        ir_d = ir_q;
        tmo_d = tmo_q;
        err_d = err_q;
        retire = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    ir_d = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                state_d = op == OP_ADD ? WB : op == OP_BEQ ? IDLE : MEM;
                retire = op == OP_BEQ;
                tmo_d = '0;
            end
            MEM: begin
                // an ack on the last allowed cycle beats the timeout
                if (bus.mem_ack) begin
                    state_d = op == OP_LW ? WB : IDLE;
                    retire = op == OP_SW;
                end else if (MEM_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WB: begin
                state_d = IDLE;
                retire = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q <= '0;
            cnt_q <= '0;
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q <= ir_d;
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    // every output is forced low while reset is held, ahead of the reset edge
    always_comb begin
        bus.instr_ready = 1'b0;
        bus.busy = 1'b0;
        bus.reg_dst = 1'b0;
        bus.reg_write = 1'b0;
        bus.alu_src = 1'b0;
        bus.branch = 1'b0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_op = 2'b00;
        bus.retired_count = '0;
        bus.timeout_err = 1'b0;
        if (rst_n) begin
            bus.instr_ready = state_q == IDLE;
            bus.busy = state_q != IDLE;
            bus.retired_count = cnt_q;
            bus.timeout_err = err_q;
            case (state_q)
                EXEC: begin
                    bus.alu_src = op == OP_LW || op == OP_SW;
                    bus.branch = op == OP_BEQ;
                    bus.alu_op = op == OP_ADD ? 2'b10 : op == OP_BEQ ? 2'b01 : 2'b00;
                end
                MEM: begin
                    bus.alu_src = 1'b1;
                    bus.mem_read = op == OP_LW;
                    bus.mem_write = op == OP_SW;
                end
                WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst = op == OP_ADD;
                    bus.mem_to_reg = op == OP_LW;
                    bus.alu_src = op == OP_LW;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: scoreboard bench; stimulus queues per-cycle expectations, monitor compares
module tb_multicycle_sequencer;
    localparam logic [10:0] RDY = 11'h400, BSY = 11'h200, RDST = 11'h100, RWR = 11'h080;
    localparam logic [10:0] ASRC = 11'h040, BR = 11'h020, MRD = 11'h010, MWR = 11'h008;
    localparam logic [10:0] M2R = 11'h004, AOP_R = 11'h002, AOP_SUB = 11'h001;

    typedef struct {
        logic [10:0] c;
        int          cnt;
        bit          err;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    rec_t q[$];
    int   m_cnt = 0;
    bit   m_err = 1'b0;
    bit   active = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    multicycle_sequencer_if #(.CNT_W(8)) b8();
    multicycle_sequencer_if #(.CNT_W(2)) b2();

    assign b2.instr_valid = b8.instr_valid;
    assign b2.instr = b8.instr;
    assign b2.mem_ack = b8.mem_ack;

    multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    always #5 clk = ~clk;

    logic [10:0] c8, c2;
    assign c8 = {b8.instr_ready, b8.busy, b8.reg_dst, b8.reg_write, b8.alu_src, b8.branch,
                 b8.mem_read, b8.mem_write, b8.mem_to_reg, b8.alu_op};
    assign c2 = {b2.instr_ready, b2.busy, b2.reg_dst, b2.reg_write, b2.alu_src, b2.branch,
                 b2.mem_read, b2.mem_write, b2.mem_to_reg, b2.alu_op};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, got, want);
        end
    endtask

    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (active) begin
                cyc++;
                if (q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd0, 32'd1);
                end else begin
                    r = q.pop_front();
                    chk("ctrl8", 32'(c8), 32'(r.c));
                    chk("ctrl2", 32'(c2), 32'(r.c));
                    chk("count8", 32'(b8.retired_count), 32'(r.cnt % 256));
                    chk("count2", 32'(b2.retired_count), 32'(r.cnt % 4));
                    chk("timeout_err8", 32'(b8.timeout_err), 32'(r.err));
                    chk("timeout_err2", 32'(b2.timeout_err), 32'(r.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [10:0] c);
        q.push_back('{c: c, cnt: m_cnt, err: m_err});
    endtask

    task automatic noise();
        b8.instr_valid = 1'($urandom);
        b8.instr = 8'($urandom);
        b8.mem_ack = 1'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            b8.instr_valid = 1'b0;
            push(RDY);
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            noise();
            q.push_back('{c: 11'h0, cnt: 0, err: 1'b0});
            tick();
        end
        rst_n = 1'b1;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    // one instruction from its accept cycle to the edge that returns to IDLE;
    // dly = MEM cycle index carrying mem_ack, rst_at = MEM cycle index with reset (-1 none)
    task automatic issue(input logic [7:0] ins, input int dly, input int rst_at);
        logic [1:0] op;
        op = ins[7:6];
        noise();
        b8.instr_valid = 1'b1;
        b8.instr = ins;
        push(RDY);
        tick();
        noise();
        push(BSY);
        tick();
        noise();
        push(op == 2'b00 ? BSY | AOP_R : op == 2'b11 ? BSY | BR | AOP_SUB : BSY | ASRC);
        tick();
        if (op == 2'b11) begin
            m_cnt++;
            return;
        end
        if (op != 2'b00) begin
            for (int k = 0; ; k++) begin
                noise();
                b8.mem_ack = k == dly;
                if (k == rst_at) begin
                    do_reset(1);
                    return;
                end
                push(BSY | ASRC | (op == 2'b01 ? MRD : MWR));
                tick();
                if (k == dly) break;
                if (k == 15) begin
                    m_err = 1'b1;
                    return;
                end
            end
            if (op == 2'b10) begin
                m_cnt++;
                return;
            end
        end
        noise();
        push(op == 2'b00 ? BSY | RWR | RDST : BSY | RWR | M2R | ASRC);
        tick();
        m_cnt++;
    endtask

    initial begin
        b8.instr_valid = 1'b0;
        b8.instr = 8'h0;
        b8.mem_ack = 1'b0;
        tick();
        active = 1'b1;
        do_reset(2);
        idle(1);
        issue(8'b00_01_10_11, 0, -1);
        issue(8'b01_00_01_10, 3, -1);
        idle(1);
        issue(8'b10_00_01_10, 100, -1);
        issue(8'b10_11_00_01, 15, -1);
        issue(8'b11_01_10_00, 0, -1);
        issue(8'b00_10_01_11, 0, -1);
        issue(8'b01_00_01_10, 100, 2);
        idle(2);
        for (int i = 0; i < 5; i++) issue(8'b00_01_10_11, 0, -1);
        for (int i = 0; i < 40; i++) begin
            int d;
            d = ($urandom % 6 == 0) ? 15 + int'($urandom % 5) : int'($urandom % 6);
            issue(8'($urandom), d, ($urandom % 15 == 0) ? int'($urandom % 3) : -1);
            idle(int'($urandom % 3));
        end
        do_reset(1);
        idle(2);
        active = 1'b0;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
